// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-address sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          PC_STEP              = 4;

  // A target is misaligned when any of its low alignBits bits is set.
  function automatic logic isMisaligned(input logic [1:0] lowBits, input int alignBits);
    logic result;
    if (alignBits <= 1) result = lowBits[0];
    else                result = |lowBits;
    return result;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection with trap, double-fault and misalignment detection.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              ALIGN_BITS  = 2
) (
  input  logic            i_stall,
  input  logic            i_branchTaken,
  input  logic [XLEN-1:0] i_branchTarget,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jumpTarget,
  input  logic            i_trap,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcPlus4,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_inTrap,
  output logic [XLEN-1:0] o_nextPc,
  output logic            o_trapEntry,
  output logic            o_doubleFault,
  output logic            o_misaligned,
  output logic            o_mretTaken
);

  logic w_mretReq;
  logic w_jumpReq;
  logic w_branchReq;
  logic w_jumpMis;
  logic w_branchMis;
  logic w_fault;

  // A stall suppresses every redirect except a trap; jump outranks branch.
  assign w_mretReq   = i_mret && !i_stall && !i_trap;
  assign w_jumpReq   = i_jump && !i_stall && !i_trap && !w_mretReq;
  assign w_branchReq = i_branchTaken && !i_stall && !i_trap && !w_mretReq && !i_jump;
  assign w_jumpMis   = isMisaligned(i_jumpTarget[1:0], ALIGN_BITS);
  assign w_branchMis = isMisaligned(i_branchTarget[1:0], ALIGN_BITS);

  assign o_misaligned  = (w_jumpReq && w_jumpMis) || (w_branchReq && w_branchMis);
  assign w_fault       = i_trap || o_misaligned;
  assign o_trapEntry   = w_fault && !i_inTrap;
  assign o_doubleFault = w_fault && i_inTrap;
  assign o_mretTaken   = w_mretReq;

  // Pick the next fetch address in redirect priority order.
  always_comb begin
    o_nextPc = i_pcPlus4;
    if (w_fault)          o_nextPc = TRAP_VECTOR;
    else if (w_mretReq)   o_nextPc = i_epc;
    else if (w_jumpReq)   o_nextPc = i_jumpTarget;
    else if (w_branchReq) o_nextPc = i_branchTarget;
    else if (i_stall)     o_nextPc = i_pc;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: boot hold-off, PC/EPC registers, trap state and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              BOOT_DELAY   = 2,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            in_trap_o,
  output logic            misaligned_o,
  output logic            halted_o
);

  localparam int              CNT_W       = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
  localparam pc_state_t       RESET_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;

  pc_state_t        r_state;
  logic [CNT_W-1:0] r_bootCnt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_epc;
  logic             r_inTrap;
  logic             r_misaligned;
  logic             r_halted;

  logic [XLEN-1:0]  w_pcPlus4;
  logic [XLEN-1:0]  w_nextPc;
  logic             w_trapEntry;
  logic             w_doubleFault;
  logic             w_misaligned;
  logic             w_mretTaken;

  assign w_pcPlus4 = r_pc + XLEN'(PC_STEP);

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_nextSel (
    .i_stall        (stall_i),
    .i_branchTaken  (branch_taken_i),
    .i_branchTarget (branch_target_i),
    .i_jump         (jump_i),
    .i_jumpTarget   (jump_target_i),
    .i_trap         (trap_i),
    .i_mret         (mret_i),
    .i_pc           (r_pc),
    .i_pcPlus4      (w_pcPlus4),
    .i_epc          (r_epc),
    .i_inTrap       (r_inTrap),
    .o_nextPc       (w_nextPc),
    .o_trapEntry    (w_trapEntry),
    .o_doubleFault  (w_doubleFault),
    .o_misaligned   (w_misaligned),
    .o_mretTaken    (w_mretTaken)
  );

  // State machine: count out the boot delay, sequence the PC in RUN, freeze in HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RESET_STATE;
      r_bootCnt    <= '0;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_inTrap     <= 1'b0;
      r_misaligned <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        BOOT: begin
          if (r_bootCnt == CNT_LAST) r_state <= RUN;
          else                       r_bootCnt <= r_bootCnt + CNT_W'(1);
        end
        RUN: begin
          r_misaligned <= w_misaligned;
          if (w_doubleFault) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_nextPc;
            if (w_trapEntry) begin
              r_epc    <= r_pc;
              r_inTrap <= 1'b1;
            end else if (w_mretTaken) begin
              r_inTrap <= 1'b0;
            end
          end
        end
        HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign pc_o         = r_pc;
  assign pc_plus4_o   = w_pcPlus4;
  assign pc_valid_o   = (r_state == RUN);
  assign epc_o        = r_epc;
  assign in_trap_o    = r_inTrap;
  assign misaligned_o = r_misaligned;
  assign halted_o     = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner cases and a randomized run against a reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        trap;
  logic        mret;

  logic [31:0] pc, pcPlus4, epc;
  logic        pcValid, inTrap, misaligned, halted;
  logic [31:0] pcA1, pcPlus4A1, epcA1;
  logic        pcValidA1, inTrapA1, misalignedA1, haltedA1;
  logic [31:0] pcB0, pcPlus4B0, epcB0;
  logic        pcValidB0, inTrapB0, misalignedB0, haltedB0;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.BOOT_DELAY(2), .ALIGN_BITS(2)) u_dut (
    .clk(clk), .reset(reset), .stall_i(stall), .branch_taken_i(branchTaken),
    .branch_target_i(branchTarget), .jump_i(jump), .jump_target_i(jumpTarget),
    .trap_i(trap), .mret_i(mret), .pc_o(pc), .pc_plus4_o(pcPlus4),
    .pc_valid_o(pcValid), .epc_o(epc), .in_trap_o(inTrap),
    .misaligned_o(misaligned), .halted_o(halted)
  );

  pc_sequencer #(.BOOT_DELAY(2), .ALIGN_BITS(1)) u_dutA1 (
    .clk(clk), .reset(reset), .stall_i(stall), .branch_taken_i(branchTaken),
    .branch_target_i(branchTarget), .jump_i(jump), .jump_target_i(jumpTarget),
    .trap_i(trap), .mret_i(mret), .pc_o(pcA1), .pc_plus4_o(pcPlus4A1),
    .pc_valid_o(pcValidA1), .epc_o(epcA1), .in_trap_o(inTrapA1),
    .misaligned_o(misalignedA1), .halted_o(haltedA1)
  );

  pc_sequencer #(.BOOT_DELAY(0), .ALIGN_BITS(2)) u_dutB0 (
    .clk(clk), .reset(reset), .stall_i(stall), .branch_taken_i(branchTaken),
    .branch_target_i(branchTarget), .jump_i(jump), .jump_target_i(jumpTarget),
    .trap_i(trap), .mret_i(mret), .pc_o(pcB0), .pc_plus4_o(pcPlus4B0),
    .pc_valid_o(pcValidB0), .epc_o(epcB0), .in_trap_o(inTrapB0),
    .misaligned_o(misalignedB0), .halted_o(haltedB0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jump;
    logic [31:0] jt;
    logic        trap;
    logic        mret;
    logic [31:0] expPc;
    logic [31:0] expEpc;
    logic        expInTrap;
    logic        expMis;
    logic        expHalted;
    logic        expValid;
    logic        chkA1;
    logic [31:0] expPcA1;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, kept in terms of the architectural rules only.
  logic [31:0] mPc, mEpc;
  logic        mInTrap, mMis, mHalted;
  int          mBootLeft;

  localparam int BOOT_DELAY_REF = 2;
  localparam int ALIGN_MOD_REF  = 4;

  function automatic vec_t mkVec(
    input logic st, input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt,
    input logic tr, input logic mr, input logic [31:0] ePc, input logic [31:0] eEpc,
    input logic eIt, input logic eMis, input logic eH, input logic eV,
    input logic cA1, input logic [31:0] eA1);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.jump = jp; v.jt = jt; v.trap = tr; v.mret = mr;
    v.expPc = ePc; v.expEpc = eEpc; v.expInTrap = eIt; v.expMis = eMis;
    v.expHalted = eH; v.expValid = eV; v.chkA1 = cA1; v.expPcA1 = eA1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt, input logic tr, input logic mr);
    stall = st; branchTaken = br; branchTarget = bt;
    jump = jp; jumpTarget = jt; trap = tr; mret = mr;
  endtask

  task automatic modelReset();
    mPc = 32'h0; mEpc = 32'h0; mInTrap = 1'b0; mMis = 1'b0; mHalted = 1'b0;
    mBootLeft = BOOT_DELAY_REF;
  endtask

  task automatic modelFault(input logic fromMisalign);
    mMis = fromMisalign;
    if (mInTrap) begin
      mHalted = 1'b1;
    end else begin
      mEpc    = mPc;
      mPc     = 32'h0000_0100;
      mInTrap = 1'b1;
    end
  endtask

  // One rising edge of the reference model.
  task automatic modelStep(input logic st, input logic br, input logic [31:0] bt,
                           input logic jp, input logic [31:0] jt, input logic tr, input logic mr);
    mMis = 1'b0;
    if (mHalted) return;
    if (mBootLeft > 0) begin
      mBootLeft--;
      return;
    end
    if (tr) modelFault(1'b0);
    else if (mr && !st) begin
      mPc = mEpc;
      mInTrap = 1'b0;
    end else if (jp && !st) begin
      if ((jt % ALIGN_MOD_REF) != 0) modelFault(1'b1);
      else mPc = jt;
    end else if (br && !st) begin
      if ((bt % ALIGN_MOD_REF) != 0) modelFault(1'b1);
      else mPc = bt;
    end else if (!st) begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "Pc"}, pc, mPc);
    checkOutput({tag, "Plus4"}, pcPlus4, mPc + 32'd4);
    checkOutput({tag, "Epc"}, epc, mEpc);
    checkOutput({tag, "InTrap"}, {31'b0, inTrap}, {31'b0, mInTrap});
    checkOutput({tag, "Mis"}, {31'b0, misaligned}, {31'b0, mMis});
    checkOutput({tag, "Halted"}, {31'b0, halted}, {31'b0, mHalted});
    checkOutput({tag, "Valid"}, {31'b0, pcValid}, {31'b0, (!mHalted && mBootLeft == 0)});
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | t[3:0];
    if ($urandom_range(0, 5) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    int haltCycles;
    logic st, br, jp, tr, mr;
    logic [31:0] bt, jt;

    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);

    // Reset values while reset is held.
    @(posedge clk); #1;
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstEpc", epc, 32'h0);
    checkOutput("rstInTrap", {31'b0, inTrap}, 32'h0);
    checkOutput("rstHalted", {31'b0, halted}, 32'h0);
    checkOutput("rstMis", {31'b0, misaligned}, 32'h0);
    checkOutput("rstValid", {31'b0, pcValid}, 32'h0);
    checkOutput("rstValidB0", {31'b0, pcValidB0}, 32'h1);
    reset = 1'b0;

    // Directed sequence following the boot, redirect, trap and wrap scenarios.
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h0,32'h0,0,0,0,0, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h0,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h4,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h8,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'hC,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h10,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,1,32'h80,1,32'h40,0,0, 32'h40,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(1,1,32'h80,0,32'h0,0,0, 32'h40,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(1,1,32'h80,0,32'h0,0,0, 32'h40,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(1,1,32'h80,0,32'h0,0,0, 32'h40,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,1,32'h20,0,32'h0,0,0, 32'h20,32'h0,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,1,0, 32'h100,32'h20,1,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,1, 32'h20,32'h20,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,1,32'h30,0,0, 32'h30,32'h20,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,1,32'h42,0,32'h0,0,0, 32'h100,32'h30,1,1,0,1, 1,32'h42));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h104,32'h30,1,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,1, 32'h30,32'h30,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,32'h30,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,0, 32'h0,32'h30,0,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,0, 32'h100,32'h0,1,0,0,1, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,0, 32'h100,32'h0,1,0,1,0, 0,32'h0));
    vecs.push_back(mkVec(0,1,32'h300,1,32'h200,0,1, 32'h100,32'h0,1,0,1,0, 0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,0, 32'h100,32'h0,1,0,1,0, 0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jump, vecs[i].jt, vecs[i].trap, vecs[i].mret);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0dPc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("vec%0dPlus4", i), pcPlus4, vecs[i].expPc + 32'd4);
      checkOutput($sformatf("vec%0dEpc", i), epc, vecs[i].expEpc);
      checkOutput($sformatf("vec%0dInTrap", i), {31'b0, inTrap}, {31'b0, vecs[i].expInTrap});
      checkOutput($sformatf("vec%0dMis", i), {31'b0, misaligned}, {31'b0, vecs[i].expMis});
      checkOutput($sformatf("vec%0dHalted", i), {31'b0, halted}, {31'b0, vecs[i].expHalted});
      checkOutput($sformatf("vec%0dValid", i), {31'b0, pcValid}, {31'b0, vecs[i].expValid});
      if (vecs[i].chkA1) begin
        checkOutput($sformatf("vec%0dPcAlign1", i), pcA1, vecs[i].expPcA1);
        checkOutput($sformatf("vec%0dMisAlign1", i), {31'b0, misalignedA1}, 32'h0);
      end
      if (i == 0) begin
        checkOutput("noBootPc", pcB0, 32'h4);
        checkOutput("noBootValid", {31'b0, pcValidB0}, 32'h1);
      end
    end

    // Asynchronous reset in the middle of a cycle while halted.
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstPc", pc, 32'h0);
    checkOutput("asyncRstHalted", {31'b0, halted}, 32'h0);
    checkOutput("asyncRstInTrap", {31'b0, inTrap}, 32'h0);
    checkOutput("asyncRstValid", {31'b0, pcValid}, 32'h0);
    #2;
    reset = 1'b0;
    modelReset();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);

    // Randomized run against the reference model, with occasional mid-cycle resets.
    haltCycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (haltCycles > 3 || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        checkOutput("rndRstPc", pc, 32'h0);
        #1;
        reset = 1'b0;
        modelReset();
        haltCycles = 0;
      end
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 2) == 0);
      jp = ($urandom_range(0, 4) == 0);
      tr = ($urandom_range(0, 24) == 0);
      mr = ($urandom_range(0, 9) == 0);
      bt = randTarget();
      jt = randTarget();
      applyStimulus(st, br, bt, jp, jt, tr, mr);
      modelStep(st, br, bt, jp, jt, tr, mr);
      @(posedge clk); #1;
      checkModel("rnd");
      if (mHalted) haltCycles++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-address generator replacing the fixed program-counter/plus-4 pair in the single-cycle core. It holds the PC register, adds a boot hold-off, prioritised redirects (trap, return, jump, branch), stall, a saved exception PC, misaligned-target trapping and a double-fault halt. It drives the instruction-memory address and feeds PC and PC+4 to the datapath.

## Interface
- XLEN, 32: address width.
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap entry.
- BOOT_DELAY, 2: cycles after reset release before fetch is valid; 0 allowed.
- ALIGN_BITS, 2: target low bits that must be zero; legal values 1 or 2.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC; blocks sequential, branch, jump and mret.
- branch_taken_i  in  1  redirect to branch_target_i.
- branch_target_i  in  XLEN  branch target.
- jump_i  in  1  redirect to jump_target_i.
- jump_target_i  in  XLEN  jump target.
- trap_i  in  1  synchronous exception request.
- mret_i  in  1  return from trap to epc_o.
- pc_o  out  XLEN  current fetch address.
- pc_plus4_o  out  XLEN  pc_o + 4, combinational, modulo 2^XLEN.
- pc_valid_o  out  1  high only in RUN.
- epc_o  out  XLEN  saved exception PC.
- in_trap_o  out  1  trap handler active.
- misaligned_o  out  1  one-cycle pulse on misaligned redirect.
- halted_o  out  1  double fault; sticky until reset.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT, or RUN directly if BOOT_DELAY == 0.
- BOOT: counter counts BOOT_DELAY cycles after reset release, then enters RUN. pc_o holds RESET_VECTOR. All request inputs are ignored.
- RUN next-PC priority is trap > mret > jump > branch > stall > sequential (pc_o + 4).
- trap_i while in_trap_o = 0 (trap entry):
  - epc_o <= pc_o; pc_o <= TRAP_VECTOR; in_trap_o <= 1.
  - Applies even when stall_i = 1.
- trap_i while in_trap_o = 1: go to HALT; halted_o <= 1.
- mret_i without stall_i: pc_o <= epc_o; in_trap_o <= 0. Allowed when in_trap_o = 0; epc_o is still used.
- Misaligned target: a jump or branch target with any of the low ALIGN_BITS bits nonzero is handled as a trap.
  - Same epc, vector and in_trap update as trap entry; misaligned_o pulses.
  - A misaligned target while in_trap_o = 1 is a double fault and goes to HALT.
- jump_i and branch_taken_i are ignored while stall_i = 1.
- Sequential increment wraps: 32'hFFFF_FFFC → 32'h0000_0000.
- HALT: pc_o, epc_o and in_trap_o are frozen; pc_valid_o = 0; all inputs ignored until reset.

## Timing
- Reset values: pc_o = RESET_VECTOR; epc_o = 0; in_trap_o = 0; halted_o = 0; misaligned_o = 0; pc_valid_o = 0, or 1 when BOOT_DELAY == 0.
- Reset is asynchronous: it clears state immediately, mid-operation included, and restarts BOOT.
- pc_valid_o first rises BOOT_DELAY rising edges after reset deasserts.
- All redirects have 1-cycle latency: a request sampled at edge N makes pc_o equal the target after edge N.
- misaligned_o is registered and high for exactly the cycle after the faulting edge.
- halted_o rises on the same edge that enters HALT.
- pc_plus4_o is combinational from pc_o, with zero latency.

## Structure
- Package pc_seq_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;
  - the default vector constants;
  - a PC_STEP = 4 constant.
- Sub-module pc_next_sel is combinational. It takes the request inputs, pc_o, epc_o and in_trap_o and returns the next PC, trap-entry, double-fault and misaligned flags.
- pc_sequencer holds the state register, boot counter, PC, EPC and flag registers.

## Test plan
- Reset with BOOT_DELAY = 2, release at t0:
  - pc_o = 0 and pc_valid_o = 0 for 2 edges;
  - then pc_o = 0x0, 0x4, 0x8 on consecutive edges.
- At pc_o = 0x10, assert jump_i (target 0x40) and branch_taken_i (target 0x80) together → next pc_o = 0x40. Then assert stall_i with branch_taken_i for 3 cycles → pc_o stays 0x40.
- At pc_o = 0x20, assert trap_i with stall_i = 1:
  - next pc_o = 0x100, epc_o = 0x20, in_trap_o = 1;
  - then mret_i → pc_o = 0x20, in_trap_o = 0.
- At pc_o = 0x30, branch to 0x42 with ALIGN_BITS = 2 → pc_o = 0x100, epc_o = 0x30, misaligned_o high for 1 cycle. Repeat with ALIGN_BITS = 1 → pc_o = 0x42.
- Assert trap_i twice without mret:
  - after the second trap, halted_o = 1, pc_valid_o = 0, and pc_o is frozen at 0x100 despite further inputs;
  - asynchronous reset mid-cycle → pc_o = 0 immediately and halted_o = 0.
- Force pc_o to 0xFFFF_FFFC via jump → next sequential pc_o = 0x0000_0000; pc_plus4_o = 0x0 while pc_o = 0xFFFF_FFFC.
